// File: rtl/seq_detect_param.sv
// seq_detect_param: serial Moore pattern detector with loadable pattern and saturating match count
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN,
  input  logic             in_valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             OUT,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             armed
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  localparam logic [FW-1:0] LAST = FW'(PAT_W - 1);
  logic [PAT_W-1:0] hist_q, hist_d, pat_q, pat_d, win;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, accept, match;
  // next state: load outranks a valid bit; a match needs PAT_W bits since the last restart
  always_comb begin
    accept = in_valid && !load;
    win    = {hist_q[PAT_W-2:0], IN};
    match  = accept && fill_q >= LAST && win == pat_q;
    hist_d = accept ? win : hist_q;
    pat_d  = load ? pat_in : pat_q;
    fill_d = (load || (match && !OVERLAP)) ? '0 :
             (accept && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
    cnt_d  = (match && !cnt_sat) ? cnt_q + 1'b1 : cnt_q;
  end
  // state registers with synchronous reset; OUT is the registered match
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PATTERN;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      out_q  <= match;
      cnt_q  <= cnt_d;
    end
  end
  assign OUT       = out_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = &cnt_q;
  assign armed     = fill_q == FULL;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: three detector configurations checked against a queue-based reference model
module tb_seq_detect_param;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       IN = 1'b0;
  logic       in_valid = 1'b0;
  logic       load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic [2:0] o, sat, arm;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  int checks = 0;
  int errors = 0;
  int n = 0;

  typedef struct packed {
    logic       out;
    logic [7:0] cnt;
    logic       sat;
    logic       armed;
  } exp_t;
  exp_t exp_q[$];

  bit         mq[3][$];
  logic [3:0] mp[3] = '{4'b1011, 4'b1011, 4'b1011};
  int         mc[3] = '{0, 0, 0};
  int         mx[3] = '{255, 255, 3};
  bit         ov[3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .IN(IN), .in_valid(in_valid), .load(load), .pat_in(pat_in),
    .OUT(o[0]), .match_cnt(c0), .cnt_sat(sat[0]), .armed(arm[0]));
  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .IN(IN), .in_valid(in_valid), .load(load), .pat_in(pat_in),
    .OUT(o[1]), .match_cnt(c1), .cnt_sat(sat[1]), .armed(arm[1]));
  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .IN(IN), .in_valid(in_valid), .load(load), .pat_in(pat_in),
    .OUT(o[2]), .match_cnt(c2), .cnt_sat(sat[2]), .armed(arm[2]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic v, input logic b, input logic [3:0] p);
    exp_t e;
    logic m;
    @(negedge clk);
    rst = r; load = l; in_valid = v; IN = b; pat_in = p;
    n++;
    for (int c = 0; c < 3; c++) begin
      m = 1'b0;
      if (r) begin
        mq[c].delete(); mp[c] = 4'b1011; mc[c] = 0;
      end else if (l) begin
        mq[c].delete(); mp[c] = p;
      end else if (v) begin
        mq[c].push_back(b);
        if (mq[c].size() > 4) void'(mq[c].pop_front());
        m = mq[c].size() == 4 && {mq[c][0], mq[c][1], mq[c][2], mq[c][3]} == mp[c];
        if (m && mc[c] < mx[c]) mc[c]++;
        if (m && !ov[c]) mq[c].delete();
      end
      e.out = m;
      e.cnt = 8'(mc[c]);
      e.sat = mc[c] == mx[c];
      e.armed = mq[c].size() == 4;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      e = exp_q.pop_front();
      chk($sformatf("s%0d.u%0d.out", n, c), 8'(o[c]), 8'(e.out));
      chk($sformatf("s%0d.u%0d.cnt", n, c), c == 0 ? c0 : c == 1 ? c1 : 8'(c2), e.cnt);
      chk($sformatf("s%0d.u%0d.sat", n, c), 8'(sat[c]), 8'(e.sat));
      chk($sformatf("s%0d.u%0d.armed", n, c), 8'(arm[c]), 8'(e.armed));
    end
  endtask

  task automatic bits(input logic [15:0] s, input int len);
    for (int i = len - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, s[i], 4'b0000);
  endtask

  task automatic reset1();
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  initial begin
    reset1();
    reset1();
    chk("rst_out", 8'(o), 8'h0);
    chk("rst_cnt", c0, 8'h0);
    bits(16'b1011, 4);
    chk("t1_out", 8'(o), 8'h7);
    chk("t1_cnt", c0, 8'd1);
    chk("t1_armed", 8'(arm[0]), 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk("t1_pulse_end", 8'(o), 8'h0);
    bits(16'b011, 3);
    chk("t2_ov_cnt", c0, 8'd2);
    chk("t2_nov_cnt", c1, 8'd1);
    chk("t2_nov_armed", 8'(arm[1]), 8'd0);
    reset1();
    bits(16'b10111011, 8);
    chk("t2b_nov_cnt", c1, 8'd2);
    chk("t2b_ov_cnt", c0, 8'd2);
    reset1();
    for (int i = 3; i >= 0; i--) begin
      step(1'b0, 1'b0, 1'b1, 4'b1011 >> i, 4'b0000);
      if (i > 0) repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    end
    chk("t3_cnt", c0, 8'd1);
    chk("t3_out", 8'(o[0]), 8'd1);
    reset1();
    bits(16'b101, 3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110);
    chk("t4_load_out", 8'(o), 8'h0);
    chk("t4_load_armed", 8'(arm), 8'h0);
    bits(16'b0110, 4);
    chk("t4_out", 8'(o[0]), 8'd1);
    chk("t4_cnt", c0, 8'd1);
    reset1();
    bits(16'b1011011011011, 13);
    chk("t5_cnt", 8'(c2), 8'd3);
    chk("t5_sat", 8'(sat[2]), 8'd1);
    chk("t5_out", 8'(o[2]), 8'd1);
    chk("t5_wide_cnt", c0, 8'd4);
    bits(16'b101, 3);
    reset1();
    bits(16'b1, 1);
    chk("t6_out", 8'(o[0]), 8'd0);
    chk("t6_armed", 8'(arm[0]), 8'd0);
    bits(16'b011, 3);
    chk("t6_out2", 8'(o[0]), 8'd1);
    chk("t6_cnt", c0, 8'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
